// File: rtl/lms_pkg.sv
// Shared types and helpers for the LMS coefficient-update stage.
// Holds default widths, the update FSM state type and the saturating add.
// No ports; imported by lms_tap_mac and lms_coef_update.
package lms_pkg;

    localparam int LMS_DW    = 14;
    localparam int LMS_CW    = 16;
    localparam int LMS_SHIFT = 13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } lms_state_t;

    // Adds a coefficient and a delta, both sign-extended to 32 bits, and
    // clamps the sum to the signed range of a cw-bit coefficient. The result
    // always fits in cw bits, so callers may truncate it to CW.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] w,
        input logic signed [31:0] delta,
        input int                 cw
    );
        logic signed [31:0] sum;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sum = w + delta;
        hi  = (32'sd1 <<< (cw - 1)) - 32'sd1;
        lo  = -(32'sd1 <<< (cw - 1));
        if (sum > hi)
            return hi;
        else if (sum < lo)
            return lo;
        else
            return sum;
    endfunction

endpackage

// File: rtl/lms_tap_mac.sv
// Single-tap LMS update: w_next = sat(w_cur + ((err * x) >>> SHIFT)).
// Latency: combinational (0 cycles).
// Backpressure: none; shared across taps through the top's index mux.
// Ports: err/x (DW signed operands), w_cur (current coefficient),
//        w_next (saturated updated coefficient).
module lms_tap_mac
    import lms_pkg::*;
#(
    parameter int DW    = LMS_DW,
    parameter int CW    = LMS_CW,
    parameter int SHIFT = LMS_SHIFT
) (
    input  logic signed [DW-1:0] err,
    input  logic signed [DW-1:0] x,
    input  logic signed [CW-1:0] w_cur,
    output logic signed [CW-1:0] w_next
);

    logic signed [2*DW-1:0] prod;
    logic signed [2*DW-1:0] delta;

    // Full-precision product; the arithmetic shift floors toward -inf.
    assign prod  = err * x;
    assign delta = prod >>> SHIFT;

    // Both operands are widened to 32 bits so the add cannot wrap before
    // clamping; the clamped value always fits back into CW bits.
    assign w_next = CW'(sat_add(32'(w_cur), 32'(delta), CW));

endmodule

// File: rtl/lms_coef_update.sv
// LMS weight update: tap delay line + coefficient file, one tap written per cycle.
// Latency: error accepted at edge T writes tap k at T+1+k; upd_done high after T+NTAPS.
// Backpressure: x_ready/err_ready low during a pass (NTAPS+1 cycles), delay line frozen.
// Ports: x_in/x_valid/x_ready sample input, err_in/err_valid/err_ready scaled error,
//        coef_clr clear-all, coef_addr/coef_rdata registered read port, upd_done pulse.
module lms_coef_update
    import lms_pkg::*;
#(
    parameter int NTAPS = 4,
    parameter int DW    = LMS_DW,
    parameter int CW    = LMS_CW,
    parameter int SHIFT = LMS_SHIFT,
    localparam int AW   = $clog2(NTAPS)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic signed [DW-1:0] x_in,
    input  logic                 x_valid,
    output logic                 x_ready,
    input  logic signed [DW-1:0] err_in,
    input  logic                 err_valid,
    output logic                 err_ready,
    input  logic                 coef_clr,
    input  logic [AW-1:0]        coef_addr,
    output logic signed [CW-1:0] coef_rdata,
    output logic                 upd_done
);

    lms_state_t          state;
    logic [AW-1:0]       idx;
    logic signed [DW-1:0] err_q;
    logic signed [DW-1:0] xdl [NTAPS];
    logic signed [CW-1:0] w   [NTAPS];
    logic signed [CW-1:0] w_next;

    // Both inputs are only accepted while no pass is running.
    assign x_ready   = (state == IDLE);
    assign err_ready = (state == IDLE);

    lms_tap_mac #(
        .DW    (DW),
        .CW    (CW),
        .SHIFT (SHIFT)
    ) u_mac (
        .err    (err_q),
        .x      (xdl[idx]),
        .w_cur  (w[idx]),
        .w_next (w_next)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            idx        <= '0;
            err_q      <= '0;
            coef_rdata <= '0;
            upd_done   <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                xdl[k] <= '0;
                w[k]   <= '0;
            end
        end else begin
            // Reads see the file as it was before this edge's write.
            coef_rdata <= w[coef_addr];

            // A sample taken on the same edge as an error lands in x[0]
            // before the pass starts reading the line.
            if (x_valid && state == IDLE) begin
                xdl[0] <= x_in;
                for (int k = 1; k < NTAPS; k++)
                    xdl[k] <= xdl[k-1];
            end

            case (state)
                IDLE: begin
                    upd_done <= 1'b0;
                    if (err_valid) begin
                        err_q <= err_in;
                        idx   <= '0;
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    w[idx] <= w_next;
                    idx    <= idx + 1'b1;
                    if (idx == AW'(NTAPS - 1)) begin
                        state    <= DONE;
                        upd_done <= 1'b1;
                    end
                end
                DONE: begin
                    upd_done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    upd_done <= 1'b0;
                    state    <= IDLE;
                end
            endcase

            // Clear overrides any tap write on this edge and kills a running
            // pass without a completion pulse.
            if (coef_clr) begin
                for (int k = 0; k < NTAPS; k++)
                    w[k] <= '0;
                if (state != IDLE) begin
                    state    <= IDLE;
                    upd_done <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lms_coef_update.sv
module tb_lms_coef_update;

    localparam int NTAPS = 4;
    localparam int DW    = 14;
    localparam int CW    = 16;
    localparam int SHIFT = 13;

    logic                 clk;
    logic                 rstn;
    logic signed [DW-1:0] x_in;
    logic                 x_valid;
    logic                 x_ready;
    logic signed [DW-1:0] err_in;
    logic                 err_valid;
    logic                 err_ready;
    logic                 coef_clr;
    logic [1:0]           coef_addr;
    logic signed [CW-1:0] coef_rdata;
    logic                 upd_done;

    int vec_cnt;
    int err_cnt;

    // Reference model state: sample line and coefficients as plain integers.
    int xm [NTAPS];
    int wm [NTAPS];

    lms_coef_update #(
        .NTAPS (NTAPS),
        .DW    (DW),
        .CW    (CW),
        .SHIFT (SHIFT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .x_in       (x_in),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .err_in     (err_in),
        .err_valid  (err_valid),
        .err_ready  (err_ready),
        .coef_clr   (coef_clr),
        .coef_addr  (coef_addr),
        .coef_rdata (coef_rdata),
        .upd_done   (upd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // floor(e*x / 2^SHIFT) using integer division with explicit floor fix-up.
    function automatic int mdl_delta(input int e, input int x);
        longint p;
        longint q;
        p = longint'(e) * longint'(x);
        q = p / (longint'(1) << SHIFT);
        if (p < 0 && (p % (longint'(1) << SHIFT)) != 0)
            q = q - 1;
        return int'(q);
    endfunction

    function automatic int mdl_clamp(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic mdl_push(input int v);
        for (int k = NTAPS - 1; k > 0; k--)
            xm[k] = xm[k-1];
        xm[0] = v;
    endtask

    task automatic mdl_pass(input int e);
        for (int k = 0; k < NTAPS; k++)
            wm[k] = mdl_clamp(wm[k] + mdl_delta(e, xm[k]));
    endtask

    task automatic mdl_reset();
        for (int k = 0; k < NTAPS; k++) begin
            xm[k] = 0;
            wm[k] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        x_in    = DW'(v);
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        mdl_push(v);
    endtask

    task automatic read_check(input string tag);
        for (int k = 0; k < NTAPS; k++) begin
            coef_addr = 2'(k);
            tick();
            chk($sformatf("%s_w%0d", tag, k), int'(coef_rdata), wm[k]);
        end
    endtask

    // Runs one full pass; optionally presents a sample on the accepting edge
    // and keeps x_valid high (with a different value) for the whole pass.
    task automatic run_pass(input int e, input bit with_x, input int xv, input bit hold_x);
        int n;
        err_in    = DW'(e);
        err_valid = 1'b1;
        if (with_x) begin
            x_in    = DW'(xv);
            x_valid = 1'b1;
            mdl_push(xv);
        end
        tick();
        err_valid = 1'b0;
        if (with_x && hold_x)
            x_in = DW'(-1234);
        else
            x_valid = 1'b0;
        chk("busy_err_ready", int'(err_ready), 0);
        chk("busy_x_ready", int'(x_ready), 0);
        n = 0;
        while (!upd_done && n < 20) begin
            tick();
            n++;
            if (!upd_done)
                chk("busy_err_ready_mid", int'(err_ready), 0);
        end
        chk("done_latency", n, NTAPS);
        x_valid = 1'b0;
        mdl_pass(e);
        tick();
        chk("done_single_cycle", int'(upd_done), 0);
        chk("idle_err_ready", int'(err_ready), 1);
    endtask

    task automatic clear_coefs();
        coef_clr = 1'b1;
        tick();
        coef_clr = 1'b0;
        for (int k = 0; k < NTAPS; k++)
            wm[k] = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        mdl_reset();
    endtask

    initial begin
        int n;
        vec_cnt   = 0;
        err_cnt   = 0;
        rstn      = 1'b0;
        x_in      = '0;
        x_valid   = 1'b0;
        err_in    = '0;
        err_valid = 1'b0;
        coef_clr  = 1'b0;
        coef_addr = '0;
        mdl_reset();

        // Reset and idle state.
        do_reset();
        chk("rst_x_ready", int'(x_ready), 1);
        chk("rst_err_ready", int'(err_ready), 1);
        chk("rst_upd_done", int'(upd_done), 0);
        chk("rst_rdata", int'(coef_rdata), 0);
        read_check("rst");

        // Basic update: two passes over a line of 4096.
        for (int i = 0; i < NTAPS; i++)
            push(4096);
        run_pass(2048, 1'b0, 0, 1'b0);
        read_check("basic1");
        run_pass(2048, 1'b0, 0, 1'b0);
        read_check("basic2");

        // A low pulse on rstn that never spans a rising edge has no effect.
        @(posedge clk);
        #2 rstn = 1'b0;
        #4 rstn = 1'b1;
        tick();
        read_check("rst_glitch");

        // Negative product truncates toward -inf.
        clear_coefs();
        for (int i = 0; i < NTAPS - 1; i++)
            push(0);
        push(1);
        run_pass(-1, 1'b0, 0, 1'b0);
        read_check("neg_trunc");

        // Positive saturation.
        clear_coefs();
        for (int i = 0; i < NTAPS; i++)
            push(8191);
        for (int p = 0; p < 5; p++) begin
            run_pass(8191, 1'b0, 0, 1'b0);
            if (p >= 3)
                read_check($sformatf("sat_pos%0d", p));
        end

        // Negative saturation.
        clear_coefs();
        for (int p = 0; p < 5; p++) begin
            run_pass(-8192, 1'b0, 0, 1'b0);
            if (p >= 3)
                read_check($sformatf("sat_neg%0d", p));
        end

        // Simultaneous sample/error accept into a zero line; x_valid held.
        do_reset();
        run_pass(2048, 1'b1, 4096, 1'b1);
        read_check("simul");
        run_pass(2048, 1'b0, 0, 1'b0);
        read_check("simul_line");

        // Abort by coef_clr at edge T+2.
        for (int i = 0; i < NTAPS; i++)
            push(1000 * (i + 1));
        err_in    = DW'(3000);
        err_valid = 1'b1;
        tick();
        err_valid = 1'b0;
        tick();
        coef_clr = 1'b1;
        tick();
        coef_clr = 1'b0;
        for (int k = 0; k < NTAPS; k++)
            wm[k] = 0;
        chk("clr_abort_idle", int'(err_ready), 1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (upd_done) n++;
            tick();
        end
        chk("clr_abort_no_done", n, 0);
        read_check("clr_abort");
        run_pass(4000, 1'b0, 0, 1'b0);
        read_check("clr_keeps_line");

        // Abort by reset at edge T+2; the line is cleared too.
        err_in    = DW'(3000);
        err_valid = 1'b1;
        tick();
        err_valid = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        mdl_reset();
        chk("rst_abort_idle", int'(err_ready), 1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (upd_done) n++;
            tick();
        end
        chk("rst_abort_no_done", n, 0);
        read_check("rst_abort");
        push(5000);
        run_pass(4000, 1'b0, 0, 1'b0);
        read_check("rst_clears_line");

        // Randomized passes against the model.
        for (int it = 0; it < 12; it++) begin
            int cnt;
            cnt = int'($urandom_range(2));
            for (int j = 0; j < cnt; j++)
                push(int'($urandom_range(16383)) - 8192);
            run_pass(int'($urandom_range(16383)) - 8192, 1'($urandom_range(1)),
                     int'($urandom_range(16383)) - 8192, 1'($urandom_range(1)));
            read_check($sformatf("rand%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/lms_coef_update.md
Name: lms_coef_update

Overview:
- LMS weight-update stage of the adaptive filter. Sits directly downstream of the step-size scaling stage (DIV) and consumes its mu-scaled error.
- Holds the input-sample tap delay line and the coefficient register file.
- On each accepted error, updates every coefficient sequentially, one tap per cycle: w[k] += (e_mu * x[k]) >>> SHIFT, with saturation.
- Coefficients are readable by the FIR datapath through a registered read port.

Parameters:
- NTAPS, 4, number of taps/coefficients (>=2).
- DW, 14, signed width of the samples and of the scaled error (matches DIV out).
- CW, 16, signed coefficient width.
- SHIFT, 13, product right-shift (Q1.13 fraction alignment).

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- x_in  in  DW  signed input sample.
- x_valid  in  1  x_in valid.
- x_ready  out  1  sample accepted when x_valid && x_ready.
- err_in  in  DW  signed mu-scaled error (from DIV).
- err_valid  in  1  err_in valid.
- err_ready  out  1  error accepted when err_valid && err_ready.
- coef_clr  in  1  synchronous clear of all coefficients.
- coef_addr  in  $clog2(NTAPS)  coefficient read index.
- coef_rdata  out  CW  registered w[coef_addr].
- upd_done  out  1  one-cycle pulse when an update pass completes.

Behaviour:
- One clock. Reset is synchronous and active-low: rstn is sampled on the rising edge of clk.
- Reset values: delay line = 0, coefficients = 0, state = IDLE, coef_rdata = 0, upd_done = 0, tap index = 0.
- Ready outputs after reset: x_ready = 1 and err_ready = 1, because both are combinational decodes of state == IDLE.
- FSM states: IDLE, UPDATE, DONE.
  - IDLE -> UPDATE on err_valid. The error is latched and the tap index is set to 0.
  - UPDATE: writes w[k] on each edge and increments k. After the write of k = NTAPS-1, moves to DONE.
  - DONE: upd_done = 1 for exactly one cycle, then returns to IDLE.
- Latency: if the error is accepted at edge T, tap k is written at edge T+1+k. upd_done is high in the cycle between edges T+NTAPS and T+NTAPS+1.
- x_ready and err_ready are 0 in UPDATE and DONE. The delay line is frozen during a pass.
- Delay-line shift on an accepted sample: x[0] <= x_in and x[k] <= x[k-1]; x[NTAPS-1] is discarded.
- Sample and error accepted on the same edge: the shift happens at that edge, and the pass uses the shifted contents (the new sample is x[0]).
- Arithmetic:
  - Product err*x[k] is a full 2*DW-bit signed value.
  - Arithmetic shift right by SHIFT, truncating toward -inf.
  - The shifted value is sign-extended to CW+1 bits and added to w[k].
  - The sum saturates to [-2^(CW-1), 2^(CW-1)-1]. No wrap-around is permitted.
- coef_clr:
  - Takes priority over the update writes: all w = 0 at that edge.
  - In UPDATE or DONE, aborts to IDLE with no upd_done pulse.
  - The delay line is unaffected.
- coef_rdata <= w[coef_addr] every edge (1-cycle latency). It reflects a write made at the same edge only on the following cycle.
- Reset mid-pass: everything returns to reset values at that edge, and no upd_done pulse is generated.
- err_valid held high across passes: the next error is accepted in the first IDLE cycle after DONE. Minimum spacing between passes is NTAPS+2 cycles.

Decomposition:
- Shared package (lms_pkg):
  - DW/CW/SHIFT defaults.
  - FSM state enum (IDLE, UPDATE, DONE).
  - Saturating-add function sat_add(w, delta) returning CW bits.
- One natural sub-module: lms_tap_mac. It computes the product, shift, and saturated add for a single tap (combinational) and is shared across taps via the index mux.
- Delay line and coefficient file stay in the top module.

Test Plan:
- Reset/idle: hold rstn=0 for 3 cycles, then release -> all coef_rdata reads return 0, x_ready=err_ready=1, upd_done=0. Confirm rstn is ignored between edges (no asynchronous effect).
- Basic update: push 4 samples of 4096, then err_in=2048 -> w[0..3]=1024. A second err of 2048 -> all w = 2048. upd_done fires exactly at T+4; err_ready is low for 5 cycles.
- Negative/truncation: delay line = {1,0,0,0}, err=-1 -> w[0] = -1 (floor of -1/8192), w[1..3] unchanged.
- Saturation: samples 8191 and err 8191 (delta 8190 per pass) -> after 4 passes w = 32760; the 5th pass gives w = 32767 (no wrap). Mirrored with err = -8192 -> clamp at -32768.
- Simultaneous accept: x_valid and err_valid at the same edge with x_in=4096 into a zero line, err=2048 -> w[0]=1024 and w[1..3]=0. x_valid held during the pass is not accepted.
- Abort: coef_clr asserted at edge T+2 of a pass -> all w = 0, state IDLE next cycle, no upd_done. Repeat with rstn=0 mid-pass -> same result, and the delay line is cleared as well.
